// File: rtl/harvard_mem_pkg.sv
// harvard_mem_pkg: shared FSM state type and default geometry for the Harvard data RAM
package harvard_mem_pkg;
    typedef enum logic {CLEAR, IDLE} state_t;
    localparam int          DEFAULT_DEPTH_WORDS = 1024;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_1000;
endpackage

// File: rtl/harvard_data_ram_if.sv
// harvard_data_ram_if: CPU data-port bus between the core and the data RAM
interface harvard_data_ram_if;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    modport master (output data_address, data_write, data_read, data_writedata, input data_readdata);
    modport slave  (input data_address, data_write, data_read, data_writedata, output data_readdata);
endinterface

// File: rtl/harvard_ram_core.sv
// harvard_ram_core: word array with one write port and one registered read port
module harvard_ram_core #(
    parameter int  DEPTH_WORDS = harvard_mem_pkg::DEFAULT_DEPTH_WORDS,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/harvard_data_ram.sv
// harvard_data_ram: cleared-on-reset data RAM with address decode, error flag and access counter
module harvard_data_ram
    import harvard_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    harvard_data_ram_if.slave   bus,
    output logic                busy,
    output logic                access_error,
    output logic [31:0]         access_count
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   offset, core_rdata;
    logic [AW-1:0] idx, mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_we, strobe, ok, wr_ok, rd_ok, have_rd_q;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign offset = bus.data_address - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign strobe = bus.data_read | bus.data_write;
    assign ok     = !reset && state_q == IDLE && bus.data_address[1:0] == 2'b00
                    && offset < SPAN && (bus.data_read ^ bus.data_write);
    assign wr_ok  = ok && bus.data_write;
    assign rd_ok  = ok && bus.data_read;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = wr_ok;
        mem_waddr = idx;
        mem_wdata = bus.data_writedata;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            ptr_d     = ptr_q + AW'(1);
            state_d   = (ptr_q == '1) ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            access_error <= 1'b0;
            access_count <= '0;
            have_rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (strobe && !ok) access_error <= 1'b1;
            if (ok) access_count <= access_count + 32'd1;
            if (rd_ok) have_rd_q <= 1'b1;
        end
    end

    harvard_ram_core #(.DEPTH_WORDS(DEPTH_WORDS)) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_ok),
        .raddr (idx),
        .rdata (core_rdata)
    );

    // The array has no reset, so the output reads zero until the first valid read.
    assign bus.data_readdata = have_rd_q ? core_rdata : '0;
    assign busy              = state_q == harvard_mem_pkg::CLEAR;
endmodule
